// File: rtl/sp_pingpong_ctrl_pkg.sv
// Shared constants and FSM state types for the ping-pong transpose controller.
package sp_pkg;
  localparam int FRAME_WORDS = 16;
  localparam int COLS        = 4;
  localparam int IDX_W       = 4;
  localparam int COL_W       = 2;

  typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} r_state_t;
endpackage

// File: rtl/sp_pingpong_ctrl_if.sv
// Upstream word handshake, storage write controls and downstream column handshake.
interface sp_pingpong_ctrl_if;
  import sp_pkg::*;

  // A transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready may drop only while no transfer fires.
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             wr_en;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             out_valid;
  logic             out_ready;
  logic             rd_bank;
  logic [COL_W-1:0] rd_col;

  modport master (
    input  in_valid, in_last, out_ready,
    output in_ready, wr_en, wr_bank, wr_idx, out_valid, rd_bank, rd_col
  );

  modport slave (
    output in_valid, in_last, out_ready,
    input  in_ready, wr_en, wr_bank, wr_idx, out_valid, rd_bank, rd_col
  );
endinterface

// File: rtl/sp_pingpong_ctrl_bank_flags.sv
// Per-bank full flags: set when a bank completes filling, cleared when it drains.
module sp_bank_flags (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       set_en,
    input  logic       set_bank,
    input  logic       clr_en,
    input  logic       clr_bank,
    output logic [1:0] full
);
    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    assign set_mask = set_en ? (2'b01 << set_bank) : 2'b00;
    assign clr_mask = clr_en ? (2'b01 << clr_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    // Filling and draining the same bank on one edge would mean the read side
    // overtook the write side.
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(set_en && clr_en && (set_bank == clr_bank)));
        end
    end
endmodule

// File: rtl/sp_pingpong_ctrl.sv
// Write/read sequencer for a two-bank 4x4 serial-to-parallel transpose buffer.
module sp_pingpong_ctrl
    import sp_pkg::*;
#(
    parameter int FRAME_WORDS = sp_pkg::FRAME_WORDS,
    parameter int COLS        = sp_pkg::COLS,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_pingpong_ctrl_if.master bus,
    input  logic              abort,
    input  logic              err_clr,
    output logic              err_len,
    output logic [1:0]        bank_full,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              frame_done,
    output w_state_t          w_state_dbg,
    output r_state_t          r_state_dbg
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    w_state_t         w_state;
    r_state_t         r_state;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_bank;
    logic [COL_W-1:0] rd_col;

    logic accept, col_fire, fill_done, short_frame, drain_done, err_set;
    logic next_wr_full, next_rd_full, cur_rd_full;

    assign bus.in_ready  = rst_n & ~abort & (w_state == W_FILL);
    assign bus.out_valid = rst_n & ~abort & (r_state == R_DRAIN);
    assign bus.wr_en     = accept;
    assign bus.wr_bank   = wr_bank;
    assign bus.wr_idx    = wr_idx;
    assign bus.rd_bank   = rd_bank;
    assign bus.rd_col    = rd_col;
    assign w_state_dbg   = w_state;
    assign r_state_dbg   = r_state;

    assign accept      = bus.in_valid & bus.in_ready;
    assign col_fire    = bus.out_valid & bus.out_ready;
    assign fill_done   = accept & (wr_idx == LAST_IDX);
    assign short_frame = accept & bus.in_last & (wr_idx != LAST_IDX);
    assign drain_done  = col_fire & (rd_col == LAST_COL);
    assign err_set     = (fill_done & ~bus.in_last) | short_frame;

    // Look-ahead fullness accounts for a set or clear landing on the same edge,
    // so bank hand-offs happen without a bubble on either side.
    assign next_wr_full = bank_full[~wr_bank] & ~(drain_done & (rd_bank == ~wr_bank));
    assign next_rd_full = bank_full[~rd_bank] | (fill_done & (wr_bank == ~rd_bank));
    assign cur_rd_full  = bank_full[rd_bank]  | (fill_done & (wr_bank == rd_bank));

    sp_bank_flags u_flags (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .set_en   (fill_done),
        .set_bank (wr_bank),
        .clr_en   (drain_done),
        .clr_bank (rd_bank),
        .full     (bank_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            w_state <= W_FILL;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            case (w_state)
                W_FILL: begin
                    if (accept) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_bank <= ~wr_bank;
                            wr_idx  <= '0;
                            w_state <= next_wr_full ? W_WAIT : W_FILL;
                        end else if (bus.in_last) begin
                            wr_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                W_WAIT: begin
                    if (!bank_full[wr_bank] || (drain_done && (rd_bank == wr_bank))) begin
                        w_state <= W_FILL;
                    end
                end
                default: w_state <= W_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            r_state <= R_IDLE;
            rd_bank <= 1'b0;
            rd_col  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (cur_rd_full) begin
                        r_state <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (col_fire) begin
                        if (rd_col == LAST_COL) begin
                            rd_col  <= '0;
                            rd_bank <= ~rd_bank;
                            r_state <= next_rd_full ? R_DRAIN : R_IDLE;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_len    <= 1'b0;
        end else if (abort) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= drain_done;
            if (drain_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (err_set) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sp_pingpong_ctrl.md
Name: sp_pingpong_ctrl

Overview:
- Controller that sequences a two-bank 4x4 serial-to-parallel transpose buffer of 34-bit words.
- Accepts one serial word per handshake into the fill bank and issues per-word write controls.
- Once a bank holds 16 words, it schedules four column reads (words k, k+4, k+8, k+12 for column k) to a downstream consumer with backpressure.
- Sits between the serial word source and the 136-bit column consumer. The controller does not touch data; it drives the storage array only.

Parameters:
- FRAME_WORDS, 16, words per frame (fixed 4x4; other values unsupported)
- COLS, 4, columns issued per frame
- CNT_W, 16, width of completed-frame counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  upstream word valid
- in_last  in  1  upstream marks final word of frame
- in_ready  out  1  controller can accept word
- wr_en  out  1  storage write strobe (combinational: in_valid & in_ready)
- wr_bank  out  1  bank being filled
- wr_idx  out  4  word slot 0..15 within wr_bank
- out_valid  out  1  column available at rd_bank/rd_col
- out_ready  in  1  downstream accepts column
- rd_bank  out  1  bank being drained
- rd_col  out  2  column 0..3 being presented
- frame_done  out  1  one-cycle pulse, registered, cycle after column 3 accepted
- abort  in  1  synchronous flush of all sequencing state
- err_clr  in  1  clears err_len
- err_len  out  1  sticky framing error
- bank_full  out  2  per-bank full flags
- frame_cnt  out  CNT_W  completed (drained) frames, wraps

Behaviour:
- Reset (rst_n=0 at edge): wr_bank=0, wr_idx=0, rd_bank=0, rd_col=0, bank_full=00, frame_done=0, err_len=0, frame_cnt=0. in_ready and out_valid are low while rst_n is low. Reset mid-frame discards all partial and full banks.
- Write FSM states:
  - W_FILL: in_ready=1.
  - W_WAIT: current wr_bank full, in_ready=0.
- Write FSM transitions:
  - On accept with wr_idx<15 and in_last=0: wr_idx++.
  - On accept with wr_idx==15: set bank_full[wr_bank], toggle wr_bank, wr_idx->0. If the new wr_bank is still full, go to W_WAIT; else stay in W_FILL. If in_last=0 here, set err_len; the frame is kept.
  - On accept with in_last=1 and wr_idx<15: set err_len, wr_idx->0, same bank refilled. The short frame is discarded and bank_full is unchanged.
  - W_WAIT -> W_FILL the cycle after bank_full[wr_bank] clears.
- Read FSM states:
  - R_IDLE: out_valid=0.
  - R_DRAIN: out_valid=1.
- Read FSM transitions:
  - Enter R_DRAIN the cycle after bank_full[rd_bank] becomes 1. Latency: first column valid 1 cycle after the 16th word is accepted.
  - In R_DRAIN, on out_valid & out_ready: rd_col++.
  - At rd_col==3 accept: clear bank_full[rd_bank], toggle rd_bank, rd_col->0, frame_done=1 next cycle, frame_cnt++ (wraps at 2^CNT_W-1 -> 0).
  - Then return to R_IDLE, or stay in R_DRAIN if the new rd_bank is already full. Back-to-back columns across banks have no bubble.
  - out_valid with out_ready=0 holds rd_bank/rd_col stable indefinitely.
- Simultaneous fill-complete and drain-complete: set and clear target different banks; both take effect the same edge. Same-bank set+clear is illegal; bench asserts it never occurs.
- Both banks full: in_ready=0 until column 3 of rd_bank is accepted. in_ready returns high the following cycle.
- abort=1 at edge: same as reset except err_len and frame_cnt are kept. abort has priority over any handshake that cycle, and in_ready/out_valid are low while abort=1.
- err_clr: clears err_len. A same-cycle new error wins (err_len stays 1).
- rst_n has priority over abort; abort has priority over err_clr.

Decomposition:
- Shared package sp_pkg:
  - FRAME_WORDS=16, COLS=4, IDX_W=4, COL_W=2
  - enum w_state_t {W_FILL, W_WAIT}
  - enum r_state_t {R_IDLE, R_DRAIN}
- One sub-module, sp_bank_flags: two full flags with set/clear ports, plus the same-bank conflict assertion.
- The write/read FSMs and counters live in the top module.

Test Plan:
- Reset, then 16 words with in_valid=1, out_ready=1, in_last on word 15:
  - wr_idx steps 0..15 on bank 0.
  - bank_full=01 the next cycle, then out_valid with rd_col 0,1,2,3 on 4 consecutive cycles.
  - frame_done pulses once; frame_cnt=1.
- out_ready=0 with 32 words continuously offered:
  - Banks 0 and 1 fill; in_ready drops after word 31; bank_full=11.
  - Assert out_ready: 8 columns issue back-to-back; in_ready returns 1 cycle after bank 0 drains.
- in_last on word 9 (wr_idx=9):
  - err_len=1, wr_idx->0, bank_full unchanged.
  - The next 16-word frame drains normally; err_clr then gives err_len=0.
- Word 15 accepted without in_last: err_len=1, the frame still drains 4 columns, frame_cnt increments.
- abort at wr_idx=7 with bank 1 full and rd_col=2:
  - Next cycle all indices are 0 and bank_full=00.
  - frame_cnt and err_len are unchanged; no frame_done pulse.
- Drain-complete of bank 0 and fill-complete of bank 1 on the same edge:
  - bank_full goes 01 -> 10.
  - out_valid stays 1 with rd_bank=1, rd_col=0; no assertion fires.
